// File: rtl/pipe_ctrl_if.sv
// Stall/flush sources from the core and the stage-register controls returned to it.
// The controller takes the slave side; the pipeline datapath takes the master side.
interface pipe_ctrl_if;
    logic hazard_stall;
    logic imem_valid;
    logic dmem_req;
    logic dmem_ack;
    logic redirect;
    logic halt;
    logic resume;

    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_bubble;
    logic mem_wb_bubble;
    logic halted;

    modport master (
        output hazard_stall, imem_valid, dmem_req, dmem_ack, redirect, halt, resume,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_bubble, mem_wb_bubble, halted
    );

    modport slave (
        input  hazard_stall, imem_valid, dmem_req, dmem_ack, redirect, halt, resume,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_bubble, mem_wb_bubble, halted
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stall/flush sources into prioritized stage
// enables and bubble controls, with saturating stall and redirect performance counters.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RUN       | normal issue; hazard / fetch-wait rules apply
// DMEM_WAIT | MEM-stage access outstanding, upstream stages frozen
// REDIRECT  | cycle after an accepted redirect; stale fetch word flushed
// HALT      | debug halt after ebreak retired; everything frozen
module pipe_ctrl #(
    parameter int STALL_CNT_W = 32,
    parameter int REDIR_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipe_ctrl_if.slave             bus,
    input  logic                   cnt_clr,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [REDIR_CNT_W-1:0] redir_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        REDIRECT  = 2'd2,
        HALT      = 2'd3
    } state_t;

    localparam logic [STALL_CNT_W-1:0] STALL_INC = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REDIR_CNT_W-1:0] REDIR_INC = {{(REDIR_CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;
    logic   halt_pend;
    logic   halt_pend_nxt;
    logic   dstall;
    logic   redir_take;

    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_bubble;
    logic mem_wb_bubble;
    logic halted;

    assign dstall = (state != HALT) && bus.dmem_req && !bus.dmem_ack;

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        halted        = 1'b0;
        redir_take    = 1'b0;
        state_nxt     = RUN;
        halt_pend_nxt = halt_pend;

        if (state == HALT) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            halted    = 1'b1;
            state_nxt = bus.resume ? RUN : HALT;
        end else if (dstall) begin
            // Frozen stages hold redirect/hazard and re-present them after the ack.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
            state_nxt     = DMEM_WAIT;
        end else if (bus.redirect && (state == RUN || state == DMEM_WAIT)) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            redir_take   = 1'b1;
            state_nxt    = REDIRECT;
        end else if (state == REDIRECT) begin
            if_id_flush = 1'b1;
        end else if (bus.hazard_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (!bus.imem_valid) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end

        // Halt waits out any data-memory stall so the retiring access completes first.
        if (state != HALT) begin
            if (dstall) begin
                if (bus.halt) begin
                    halt_pend_nxt = 1'b1;
                end
            end else if (bus.halt || halt_pend) begin
                state_nxt     = HALT;
                halt_pend_nxt = 1'b0;
            end
        end

        if (!rst_n) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
            halted        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            halt_pend <= 1'b0;
            stall_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            state     <= state_nxt;
            halt_pend <= halt_pend_nxt;
            if (cnt_clr) begin
                stall_cnt <= '0;
                redir_cnt <= '0;
            end else begin
                if (state != HALT && !pc_en && stall_cnt != '1) begin
                    stall_cnt <= stall_cnt + STALL_INC;
                end
                if (redir_take && redir_cnt != '1) begin
                    redir_cnt <= redir_cnt + REDIR_INC;
                end
            end
        end
    end

    assign bus.pc_en         = pc_en;
    assign bus.if_id_en      = if_id_en;
    assign bus.id_ex_en      = id_ex_en;
    assign bus.ex_mem_en     = ex_mem_en;
    assign bus.mem_wb_en     = mem_wb_en;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_bubble  = id_ex_bubble;
    assign bus.mem_wb_bubble = mem_wb_bubble;
    assign bus.halted        = halted;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each driven cycle pushes its expected controls and
// counter values; a negedge monitor pops and compares against the DUT.
module tb_pipe_ctrl;

    localparam int SW = 4;
    localparam int RW = 3;
    localparam int SMAX = (1 << SW) - 1;
    localparam int RMAX = (1 << RW) - 1;

    // expected control word: pc,if_id,id_ex,ex_mem,mem_wb,flush,id_ex_bub,mem_wb_bub,halted
    localparam logic [8:0] RUNALL = 9'b11111_000_0;
    localparam logic [8:0] HZ     = 9'b00111_010_0;
    localparam logic [8:0] FRZ    = 9'b00001_001_0;
    localparam logic [8:0] RDR    = 9'b11111_110_0;
    localparam logic [8:0] RDS    = 9'b11111_100_0;
    localparam logic [8:0] NOIV   = 9'b01111_100_0;
    localparam logic [8:0] HLT    = 9'b00000_000_1;
    localparam logic [8:0] RST    = 9'b00000_111_0;

    // stimulus word: hazard,imem_valid,dmem_req,dmem_ack,redirect,halt,resume,cnt_clr
    localparam logic [7:0] I   = 8'b0100_0000;
    localparam logic [7:0] HZI = 8'b1100_0000;
    localparam logic [7:0] RQ  = 8'b0110_0000;
    localparam logic [7:0] RQA = 8'b0111_0000;
    localparam logic [7:0] RDI = 8'b0100_1000;
    localparam logic [7:0] HLI = 8'b0100_0100;
    localparam logic [7:0] RSI = 8'b0100_0010;
    localparam logic [7:0] CLI = 8'b0100_0001;

    logic clk = 1'b0;
    logic rst_n;
    logic cnt_clr;
    logic [SW-1:0] stall_cnt;
    logic [RW-1:0] redir_cnt;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.STALL_CNT_W(SW), .REDIR_CNT_W(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .redir_cnt (redir_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [8:0] ctl;
        int         stall;
        int         redir;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_stall = 0;
    int   m_redir = 0;

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [8:0] ctl_now();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                bus.if_id_flush, bus.id_ex_bubble, bus.mem_wb_bubble, bus.halted};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({e.tag, ":ctl"}, int'(ctl_now()), int'(e.ctl));
            chk({e.tag, ":stall"}, int'(stall_cnt), e.stall);
            chk({e.tag, ":redir"}, int'(redir_cnt), e.redir);
        end
    end

    // Called just after a rising edge; drives one cycle and records its expectation.
    task automatic cyc(string tag, logic [7:0] in, logic [8:0] ex);
        {bus.hazard_stall, bus.imem_valid, bus.dmem_req, bus.dmem_ack,
         bus.redirect, bus.halt, bus.resume, cnt_clr} = in;
        sb_q.push_back('{tag: tag, ctl: ex, stall: m_stall, redir: m_redir});
        if (in[0]) begin
            m_stall = 0;
            m_redir = 0;
        end else begin
            if (!ex[8] && !ex[0] && m_stall < SMAX) m_stall++;
            if (ex[8] && ex[3] && ex[2] && m_redir < RMAX) m_redir++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ":ctl"}, int'(ctl_now()), int'(RST));
        chk({tag, ":stall"}, int'(stall_cnt), 0);
        chk({tag, ":redir"}, int'(redir_cnt), 0);
        m_stall = 0;
        m_redir = 0;
        {bus.hazard_stall, bus.imem_valid, bus.dmem_req, bus.dmem_ack,
         bus.redirect, bus.halt, bus.resume, cnt_clr} = I;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        {bus.hazard_stall, bus.imem_valid, bus.dmem_req, bus.dmem_ack,
         bus.redirect, bus.halt, bus.resume, cnt_clr} = I;
        #2;
        do_reset("por");

        cyc("run0", I, RUNALL);

        cyc("hz1", HZI, HZ);
        cyc("hz2", HZI, HZ);
        cyc("hz3", I, RUNALL);
        cyc("clr", CLI, RUNALL);

        cyc("dw1", RQ, FRZ);
        cyc("dw2", RQ, FRZ);
        cyc("dw3", RQA, RUNALL);
        cyc("dw4", I, RUNALL);
        cyc("dz", RQA, RUNALL);
        cyc("dz2", I, RUNALL);

        cyc("dri", RQ | HZI | RDI, FRZ);
        cyc("drack", RQA | RDI, RDR);
        cyc("rds_hz", HZI, RDS);
        cyc("rds_x", I, RUNALL);

        cyc("rh", HZI | RDI, RDR);
        cyc("rs", I, RDS);
        cyc("rs_x", I, RUNALL);

        cyc("nv", 8'h00, NOIV);
        cyc("nv_x", I, RUNALL);

        cyc("hd1", RQ | HLI, FRZ);
        cyc("hd2", RQ, FRZ);
        cyc("hd3", RQA, RUNALL);
        cyc("hlt1", I, HLT);
        cyc("hlt2", I, HLT);
        cyc("res", RSI, HLT);
        cyc("aft", I, RUNALL);

        cyc("hn", HLI, RUNALL);
        cyc("hh", HLI | RSI, HLT);
        cyc("hh_x", I, RUNALL);
        cyc("rnh", RSI, RUNALL);
        cyc("rnh_x", I, RUNALL);

        for (int i = 0; i < 20; i++) cyc("sat_hz", HZI, HZ);
        cyc("sat_a", I, RUNALL);
        cyc("sat_b", I, RUNALL);
        cyc("sat_clr", CLI, RUNALL);
        cyc("sat_z", I, RUNALL);

        for (int i = 0; i < 9; i++) begin
            cyc("rsat_r", RDI, RDR);
            cyc("rsat_s", I, RDS);
        end
        cyc("rsat_x", I, RUNALL);

        cyc("mr_w", RQ | HLI, FRZ);
        do_reset("mr_dw");
        cyc("mr_dw1", I, RUNALL);
        cyc("mr_dw2", I, RUNALL);

        cyc("mr_r", RDI, RDR);
        do_reset("mr_rd");
        cyc("mr_rd1", I, RUNALL);

        cyc("mr_h", HLI, RUNALL);
        cyc("mr_h1", I, HLT);
        do_reset("mr_hl");
        cyc("mr_hl1", I, RUNALL);

        @(negedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
